// File: rtl/tt_mux_pkg.sv
// Shared types, default widths and helpers for the multi-slot project controller.
// Optional feature macro: TT_MUX_OUT_REG_EN (registered ow output, see tt_mux_ow_sel).
package tt_mux_pkg;

  // Default configuration and the widths derived from it.
  localparam int unsigned NProjDef    = 16;
  localparam int unsigned IwWDef      = 18;
  localparam int unsigned OwWDef      = 24;
  localparam int unsigned GuardCycDef = 4;
  localparam int unsigned RstHoldDef  = 8;
  localparam int unsigned AddrWDef    = $clog2(NProjDef);

  // Upper bounds for the generic slice helper; N_PROJ*OW_W must not exceed BusMax.
  localparam int unsigned OwMax  = 64;
  localparam int unsigned BusMax = 1024;

  // Controller states, kept as plain constants for older tool flows.
  typedef logic [1:0] state_t;
  localparam state_t StIdle  = 2'd0;
  localparam state_t StGuard = 2'd1;
  localparam state_t StHold  = 2'd2;
  localparam state_t StRun   = 2'd3;

  // Counter width that holds max(guard, hold) without wrapping.
  function automatic int unsigned cnt_w(input int unsigned guard_cyc, input int unsigned rst_hold);
    int unsigned m;
    m = (guard_cyc > rst_hold) ? guard_cyc : rst_hold;
    return $clog2(m + 1);
  endfunction

  // Slice idx of a packed bus of ow_w-bit fields; caller truncates to its own width.
  function automatic logic [OwMax-1:0] ow_slice(input logic [BusMax-1:0] bus,
                                                input int unsigned idx,
                                                input int unsigned ow_w);
    logic [BusMax-1:0] sh;
    sh = bus >> (idx * ow_w);
    return sh[OwMax-1:0];
  endfunction

endpackage

// File: rtl/tt_mux_ow_sel.sv
// N_PROJ:1 selector of OW_W-bit slot output slices.
// With TT_MUX_OUT_REG_EN defined the result is registered (one extra cycle, cleared
// whenever the controller is not about to be in RUN); otherwise it is purely combinational.
module tt_mux_ow_sel
  import tt_mux_pkg::*;
#(
  parameter int unsigned N_PROJ = NProjDef,
  parameter int unsigned OW_W   = OwWDef,
  parameter int unsigned ADDR_W = AddrWDef
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_PROJ*OW_W-1:0]   proj_ow_i,
  input  logic [ADDR_W-1:0]        idx_i,
  input  logic                     run_i,
  input  logic [ADDR_W-1:0]        idx_nxt_i,
  input  logic                     run_nxt_i,
  output logic [OW_W-1:0]          ow_o
);

  localparam int unsigned BusW = N_PROJ * OW_W;

  logic [BusMax-1:0] bus_ext;

  // Zero-extend the slot bus to the helper's fixed width.
  always_comb begin
    bus_ext          = '0;
    bus_ext[BusW-1:0] = proj_ow_i;
  end

`ifdef TT_MUX_OUT_REG_EN
  logic [OW_W-1:0] ow_d, ow_q;
  logic            unused_cur;

  // Next output value: the slice the controller will present once it is in RUN.
  always_comb begin
    ow_d = '0;
    if (run_nxt_i) ow_d = OW_W'(ow_slice(bus_ext, 32'(idx_nxt_i), OW_W));
  end

  // Output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ow_q <= '0;
    else     ow_q <= ow_d;
  end

  assign ow_o       = ow_q;
  assign unused_cur = ^{run_i, idx_i};
`else
  logic unused_reg;

  // Combinational selection, forced to zero outside RUN.
  always_comb begin
    ow_o = '0;
    if (run_i) ow_o = OW_W'(ow_slice(bus_ext, 32'(idx_i), OW_W));
  end

  assign unused_reg = ^{clk, rst, run_nxt_i, idx_nxt_i};
`endif

endmodule

// File: rtl/tt_mux_slot_ctrl.sv
// Multi-slot project controller: break-before-make slot switching with a guard
// interval, per-slot reset hold, iw gating and ow return selection.
// Optional feature macro: TT_MUX_OUT_REG_EN (registered ow, handled in tt_mux_ow_sel).
module tt_mux_slot_ctrl
  import tt_mux_pkg::*;
#(
  parameter int unsigned N_PROJ    = NProjDef,
  parameter int unsigned IW_W      = IwWDef,
  parameter int unsigned OW_W      = OwWDef,
  parameter int unsigned GUARD_CYC = GuardCycDef,
  parameter int unsigned RST_HOLD  = RstHoldDef
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        sel_valid,
  output logic                        sel_ready,
  input  logic [$clog2(N_PROJ)-1:0]   sel_addr,
  output logic                        sel_err,
  input  logic [IW_W-1:0]             iw,
  output logic [IW_W-1:0]             proj_iw,
  output logic [N_PROJ-1:0]           proj_ena,
  input  logic [N_PROJ*OW_W-1:0]      proj_ow,
  output logic [OW_W-1:0]             ow,
  output logic                        active,
  output logic [$clog2(N_PROJ)-1:0]   cur_addr
);

  localparam int unsigned AW = $clog2(N_PROJ);
  localparam int unsigned CW = cnt_w(GUARD_CYC, RST_HOLD);

  state_t            state_d, state_q;
  logic [CW-1:0]     cnt_d, cnt_q;
  logic [AW-1:0]     addr_d, addr_q;
  logic [AW-1:0]     cur_addr_d, cur_addr_q;
  logic [N_PROJ-1:0] ena_d, ena_q;
  logic              err_d, err_q;
  logic              accept;
  logic              addr_ok;

  assign sel_ready = (state_q == StIdle) || (state_q == StRun);
  assign accept    = sel_valid && sel_ready;
  assign addr_ok   = (32'(sel_addr) < N_PROJ);

  // Next-state logic: FSM, guard/hold counter, latched request and enables.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    cur_addr_d = cur_addr_q;
    ena_d      = ena_q;
    err_d      = 1'b0;
    case (state_q)
      StIdle: begin
        if (accept) begin
          if (addr_ok) begin
            addr_d  = sel_addr;
            cnt_d   = '0;
            state_d = StGuard;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StGuard: begin
        // Enable rises GUARD_CYC+1 edges after the accepting edge.
        if (cnt_q == CW'(GUARD_CYC)) begin
          ena_d      = N_PROJ'(1) << addr_q;
          cur_addr_d = addr_q;
          cnt_d      = '0;
          state_d    = StHold;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StHold: begin
        if (cnt_q == CW'(RST_HOLD - 1)) begin
          cnt_d   = '0;
          state_d = StRun;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StRun: begin
        if (accept) begin
          // Break before make: the old slot drops on the accepting edge.
          ena_d = '0;
          if (addr_ok) begin
            addr_d  = sel_addr;
            cnt_d   = '0;
            state_d = StGuard;
          end else begin
            err_d   = 1'b1;
            state_d = StIdle;
          end
        end
      end
      default: begin
        ena_d   = '0;
        cnt_d   = '0;
        state_d = StIdle;
      end
    endcase
  end

  // Controller state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      addr_q     <= '0;
      cur_addr_q <= '0;
      ena_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      cur_addr_q <= cur_addr_d;
      ena_q      <= ena_d;
      err_q      <= err_d;
    end
  end

  // Input gating: slots see nothing until enabled, and rst_n (bit1) low during hold.
  always_comb begin
    proj_iw = '0;
    case (state_q)
      StHold: begin
        proj_iw    = iw;
        proj_iw[1] = 1'b0;
      end
      StRun:   proj_iw = iw;
      default: proj_iw = '0;
    endcase
  end

  assign proj_ena = ena_q;
  assign sel_err  = err_q;
  assign active   = (state_q == StRun);
  assign cur_addr = cur_addr_q;

  tt_mux_ow_sel #(
    .N_PROJ (N_PROJ),
    .OW_W   (OW_W),
    .ADDR_W (AW)
  ) u_ow_sel (
    .clk       (clk),
    .rst       (rst),
    .proj_ow_i (proj_ow),
    .idx_i     (cur_addr_q),
    .run_i     (state_q == StRun),
    .idx_nxt_i (cur_addr_d),
    .run_nxt_i (state_d == StRun),
    .ow_o      (ow)
  );

endmodule

// File: tb/tb_tt_mux_slot_ctrl.sv
// Directed self-checking bench for tt_mux_slot_ctrl.
// Uses 12 slots so that a 4-bit sel_addr can express out-of-range requests (12..15);
// with 16 slots every 4-bit address would be valid.
module tb_tt_mux_slot_ctrl;

  localparam int unsigned NP = 12;
  localparam int unsigned IWW = 18;
  localparam int unsigned OWW = 24;
  localparam int unsigned GC = 4;
  localparam int unsigned RH = 8;
  localparam int unsigned AW = $clog2(NP);

  logic              clk = 1'b0;
  logic              rst;
  logic              sel_valid;
  logic              sel_ready;
  logic [AW-1:0]     sel_addr;
  logic              sel_err;
  logic [IWW-1:0]    iw;
  logic [IWW-1:0]    proj_iw;
  logic [NP-1:0]     proj_ena;
  logic [NP*OWW-1:0] proj_ow;
  logic [OWW-1:0]    ow;
  logic              active;
  logic [AW-1:0]     cur_addr;

  int checks = 0;
  int errors = 0;

  tt_mux_slot_ctrl #(
    .N_PROJ    (NP),
    .IW_W      (IWW),
    .OW_W      (OWW),
    .GUARD_CYC (GC),
    .RST_HOLD  (RH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sel_valid (sel_valid),
    .sel_ready (sel_ready),
    .sel_addr  (sel_addr),
    .sel_err   (sel_err),
    .iw        (iw),
    .proj_iw   (proj_iw),
    .proj_ena  (proj_ena),
    .proj_ow   (proj_ow),
    .ow        (ow),
    .active    (active),
    .cur_addr  (cur_addr)
  );

  always #5 clk = ~clk;

  // Distinct per-slot output pattern, e.g. slot 3 -> 24'hA50303.
  function automatic logic [OWW-1:0] pat(input int k);
    return 24'hA50000 | 24'(k * 257);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Request slot a from IDLE or RUN and follow guard, hold and run entry.
  task automatic do_select(input int a);
    sel_valid = 1'b1;
    sel_addr  = AW'(a);
    tick();
    sel_valid = 1'b0;
    for (int i = 0; i < GC + 1; i++) begin
      check("guard_ena", 32'(proj_ena), 32'h0);
      check("guard_iw", 32'(proj_iw), 32'h0);
      check("guard_ow", 32'(ow), 32'h0);
      check("guard_ready", 32'(sel_ready), 32'h0);
      tick();
    end
    check("hold_ena", 32'(proj_ena), 32'(1) << a);
    check("hold_cur_addr", 32'(cur_addr), 32'(a));
    for (int i = 0; i < RH; i++) begin
      check("hold_iw", 32'(proj_iw), 32'(iw & ~18'h2));
      check("hold_active", 32'(active), 32'h0);
      check("hold_ow", 32'(ow), 32'h0);
      tick();
    end
    check("run_active", 32'(active), 32'h1);
    check("run_ena", 32'(proj_ena), 32'(1) << a);
    check("run_iw", 32'(proj_iw), 32'(iw));
    check("run_ow", 32'(ow), 32'(pat(a)));
    check("run_ready", 32'(sel_ready), 32'h1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ena"}, 32'(proj_ena), 32'h0);
    check({tag, "_ow"}, 32'(ow), 32'h0);
    check({tag, "_iw"}, 32'(proj_iw), 32'h0);
    check({tag, "_ready"}, 32'(sel_ready), 32'h1);
    check({tag, "_active"}, 32'(active), 32'h0);
    check({tag, "_err"}, 32'(sel_err), 32'h0);
    check({tag, "_cur_addr"}, 32'(cur_addr), 32'h0);
  endtask

  initial begin
    rst       = 1'b1;
    sel_valid = 1'b0;
    sel_addr  = '0;
    iw        = 18'h12347;
    for (int k = 0; k < int'(NP); k++) proj_ow[k*OWW +: OWW] = pat(k);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Idle after reset; gating holds for any iw.
    check_reset_outputs("idle");
    iw = 18'h3FFFF;
    #1;
    check("idle_iw_ones", 32'(proj_iw), 32'h0);
    iw = 18'h12347;

    // First selection and run-time tracking.
    do_select(3);
    iw = 18'h30F0E;
    #1;
    check("run_iw_follow", 32'(proj_iw), 32'h30F0E);
    proj_ow[3*OWW +: OWW] = 24'h123456;
`ifdef TT_MUX_OUT_REG_EN
    #1;
    check("run_ow_late", 32'(ow), 32'(pat(3)));
    tick();
`else
    #1;
`endif
    check("run_ow_follow", 32'(ow), 32'h123456);
    proj_ow[3*OWW +: OWW] = pat(3);
    tick();

    // Switch 3 -> 7, then 7 -> 5.
    do_select(7);
    check("sw_cur_addr", 32'(cur_addr), 32'h7);
    do_select(5);

    // Out-of-range request while running slot 5.
    sel_valid = 1'b1;
    sel_addr  = AW'(13);
    tick();
    sel_valid = 1'b0;
    check("bad_err", 32'(sel_err), 32'h1);
    check("bad_ena", 32'(proj_ena), 32'h0);
    check("bad_active", 32'(active), 32'h0);
    check("bad_ow", 32'(ow), 32'h0);
    check("bad_iw", 32'(proj_iw), 32'h0);
    check("bad_ready", 32'(sel_ready), 32'h1);
    check("bad_cur_addr", 32'(cur_addr), 32'h5);
    tick();
    check("bad_err_pulse", 32'(sel_err), 32'h0);
    check("bad_idle_ena", 32'(proj_ena), 32'h0);

    // Out-of-range request from IDLE: error pulse, stays idle.
    sel_valid = 1'b1;
    sel_addr  = AW'(12);
    tick();
    sel_valid = 1'b0;
    check("idle_bad_err", 32'(sel_err), 32'h1);
    check("idle_bad_ready", 32'(sel_ready), 32'h1);
    tick();
    check("idle_bad_err_pulse", 32'(sel_err), 32'h0);
    check("idle_bad_ena", 32'(proj_ena), 32'h0);

    // Reset during GUARD.
    sel_valid = 1'b1;
    sel_addr  = AW'(2);
    tick();
    sel_valid = 1'b0;
    tick();
    check("pre_rst_guard_ready", 32'(sel_ready), 32'h0);
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_guard");
    tick();
    rst = 1'b0;
    tick();

    // Reset during HOLD.
    sel_valid = 1'b1;
    sel_addr  = AW'(9);
    tick();
    sel_valid = 1'b0;
    for (int i = 0; i < GC + 1 + 3; i++) tick();
    check("pre_rst_hold_ena", 32'(proj_ena), 32'h200);
    check("pre_rst_hold_iw", 32'(proj_iw), 32'(iw & ~18'h2));
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_hold");
    tick();
    rst = 1'b0;
    tick();
    check_reset_outputs("post_rst");

    // Recovery after reset.
    do_select(1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
